// File: rtl/rr_array_arbiter_if.sv
// Request/grant and shared-sink signals of the round-robin array arbiter.
// The slave modport is the arbiter's view; master is the requester/sink side.
interface rr_array_arbiter_if #(
    parameter int unsigned M = 2,
    parameter int unsigned W = 8
);
    localparam int unsigned SW = (M > 1) ? $clog2(M) : 1;

    logic          req      [M];
    logic          req_last [M];
    logic [W-1:0]  req_data [M];
    logic          gnt      [M];
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic [SW-1:0] out_src;
    logic          out_ready;

    modport slave (
        input  req, req_last, req_data, out_ready,
        output gnt, out_valid, out_data, out_last, out_src
    );

    modport master (
        output req, req_last, req_data, out_ready,
        input  gnt, out_valid, out_data, out_last, out_src
    );
endinterface

// File: rtl/rr_array_arbiter.sv
// Burst-granular round-robin arbiter: M requesters share one sink; a grant is held
// until the owner's last beat is accepted or the owner drops its request.
module rr_array_arbiter #(
    parameter int unsigned M = 2,
    parameter int unsigned W = 8
) (
    input  logic              clock,
    input  logic              reset,
    rr_array_arbiter_if.slave arb_io
);
    localparam int unsigned SW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [SW-1:0] owner_q, owner_d;
    logic          gnt_q [M];
    logic          gnt_d [M];

    logic          any_req;
    logic [SW-1:0] pick;
    int unsigned   idx;
    logic [SW-1:0] owner_inc;
    logic          own_req;
    logic          xfer;
    logic          release_own;

    // Rotating scan: first requester at or after ptr, wrapping modulo M.
    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        idx     = 0;
        for (int unsigned k = 0; k < M; k++) begin
            idx = (32'(ptr_q) + k) % M;
            if (!any_req && arb_io.req[idx]) begin
                any_req = 1'b1;
                pick    = SW'(idx);
            end
        end
    end

    always_comb begin
        owner_inc   = (owner_q == SW'(M - 1)) ? '0 : owner_q + 1'b1;
        own_req     = arb_io.req[owner_q];
        xfer        = (state_q == StBusy) && own_req && arb_io.out_ready;
        // A dropped request ends the burst exactly like an accepted last beat.
        release_own = (state_q == StBusy) &&
                      (!own_req || (xfer && arb_io.req_last[owner_q]));
    end

    always_comb begin
        arb_io.out_valid = 1'b0;
        arb_io.out_data  = '0;
        arb_io.out_last  = 1'b0;
        arb_io.out_src   = '0;
        if (state_q == StBusy) begin
            arb_io.out_valid = own_req;
            arb_io.out_data  = arb_io.req_data[owner_q];
            arb_io.out_last  = arb_io.req_last[owner_q];
            arb_io.out_src   = owner_q;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StBusy;
                    owner_d = pick;
                    for (int unsigned i = 0; i < M; i++) begin
                        gnt_d[i] = (SW'(i) == pick);
                    end
                end
            end
            StBusy: begin
                if (release_own) begin
                    state_d = StIdle;
                    ptr_d   = owner_inc;
                    for (int unsigned i = 0; i < M; i++) begin
                        gnt_d[i] = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            for (int unsigned i = 0; i < M; i++) begin
                gnt_q[i] <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            for (int unsigned i = 0; i < M; i++) begin
                gnt_q[i] <= gnt_d[i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < M; i++) begin
            arb_io.gnt[i] = gnt_q[i];
        end
    end
endmodule

// File: tb/tb_rr_array_arbiter.sv
// Directed bench for rr_array_arbiter with M=4, M=2 and M=1 instances side by side.
module tb_rr_array_arbiter;
    logic clock = 1'b0;
    logic rst4, rst2, rst1;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    rr_array_arbiter_if #(.M(4), .W(8)) if4 ();
    rr_array_arbiter_if #(.M(2), .W(8)) if2 ();
    rr_array_arbiter_if #(.M(1), .W(8)) if1 ();

    rr_array_arbiter #(.M(4), .W(8)) dut4 (.clock(clock), .reset(rst4), .arb_io(if4));
    rr_array_arbiter #(.M(2), .W(8)) dut2 (.clock(clock), .reset(rst2), .arb_io(if2));
    rr_array_arbiter #(.M(1), .W(8)) dut1 (.clock(clock), .reset(rst1), .arb_io(if1));

    logic [3:0] g4;
    logic [1:0] g2;
    logic       g1;
    always_comb begin
        for (int i = 0; i < 4; i++) g4[i] = if4.gnt[i];
        for (int i = 0; i < 2; i++) g2[i] = if2.gnt[i];
        g1 = if1.gnt[0];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear4();
        for (int i = 0; i < 4; i++) begin
            if4.req[i] = 1'b0; if4.req_last[i] = 1'b0; if4.req_data[i] = 8'h00;
        end
        if4.out_ready = 1'b0;
    endtask

    task automatic clear2();
        for (int i = 0; i < 2; i++) begin
            if2.req[i] = 1'b0; if2.req_last[i] = 1'b0; if2.req_data[i] = 8'h00;
        end
        if2.out_ready = 1'b0;
    endtask

    task automatic clear1();
        if1.req[0] = 1'b0; if1.req_last[0] = 1'b0; if1.req_data[0] = 8'h00;
        if1.out_ready = 1'b0;
    endtask

    task automatic do_reset4();
        rst4 = 1'b1; clear4(); tick(); rst4 = 1'b0;
    endtask

    task automatic do_reset2();
        rst2 = 1'b1; clear2(); tick(); rst2 = 1'b0;
    endtask

    task automatic do_reset1();
        rst1 = 1'b1; clear1(); tick(); rst1 = 1'b0;
    endtask

    // Reset wins even with every request, last and ready held high.
    task automatic test_reset();
        rst4 = 1'b1; rst2 = 1'b1; rst1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if4.req[i] = 1'b1; if4.req_last[i] = 1'b1; if4.req_data[i] = 8'hFF;
        end
        for (int i = 0; i < 2; i++) begin
            if2.req[i] = 1'b1; if2.req_last[i] = 1'b1; if2.req_data[i] = 8'hFF;
        end
        if1.req[0] = 1'b1; if1.req_last[0] = 1'b1; if1.req_data[0] = 8'hFF;
        if4.out_ready = 1'b1; if2.out_ready = 1'b1; if1.out_ready = 1'b1;
        tick(); tick();
        total++; if (g4 !== 4'b0000) begin bad++; $display("FAIL reset_gnt4 got=%b want=0000", g4); end
        total++; if (g2 !== 2'b00) begin bad++; $display("FAIL reset_gnt2 got=%b want=00", g2); end
        total++; if (g1 !== 1'b0) begin bad++; $display("FAIL reset_gnt1 got=%b want=0", g1); end
        total++; if (if4.out_valid !== 1'b0 || if4.out_data !== 8'h00 || if4.out_last !== 1'b0
                     || if4.out_src !== 2'd0) begin
            bad++;
            $display("FAIL reset_out4 got v=%b d=%h l=%b s=%0d want all 0",
                     if4.out_valid, if4.out_data, if4.out_last, if4.out_src);
        end
        clear4(); clear2(); clear1();
        rst4 = 1'b0; rst2 = 1'b0; rst1 = 1'b0;
        tick();
        total++; if (g4 !== 4'b0000) begin bad++; $display("FAIL idle_no_req got=%b want=0000", g4); end
    endtask

    // All four single-beat requesters: order 0,1,2,3,0 with one idle cycle between grants.
    task automatic test_rr_order();
        int         order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] e;
        do_reset4();
        for (int i = 0; i < 4; i++) begin
            if4.req[i] = 1'b1; if4.req_last[i] = 1'b1; if4.req_data[i] = 8'hA0 + 8'(i);
        end
        if4.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            e = 4'b0001 << order[k];
            total++; if (g4 !== e) begin bad++; $display("FAIL rr_gnt%0d got=%b want=%b", k, g4, e); end
            total++; if (if4.out_src !== 2'(order[k]) || if4.out_data !== 8'hA0 + 8'(order[k])
                         || if4.out_valid !== 1'b1) begin
                bad++;
                $display("FAIL rr_out%0d got s=%0d d=%h v=%b want s=%0d d=%h v=1", k,
                         if4.out_src, if4.out_data, if4.out_valid, order[k], 8'hA0 + 8'(order[k]));
            end
            tick();
            total++; if (g4 !== 4'b0000 || if4.out_valid !== 1'b0) begin
                bad++; $display("FAIL rr_idle%0d got gnt=%b v=%b want 0000 0", k, g4, if4.out_valid);
            end
        end
        clear4();
    endtask

    // Pointer at 3 with requesters 1 and 3: 3 first, then wrap to 0 and grant 1.
    task automatic test_ptr_skip();
        do_reset4();
        if4.req[2] = 1'b1; if4.req_last[2] = 1'b1; if4.out_ready = 1'b1;
        tick();
        total++; if (g4 !== 4'b0100) begin bad++; $display("FAIL ptr_pre got=%b want=0100", g4); end
        tick();
        if4.req[2] = 1'b0;
        if4.req[1] = 1'b1; if4.req_last[1] = 1'b1; if4.req_data[1] = 8'h31;
        if4.req[3] = 1'b1; if4.req_last[3] = 1'b1; if4.req_data[3] = 8'h33;
        tick();
        total++; if (g4 !== 4'b1000 || if4.out_src !== 2'd3) begin
            bad++; $display("FAIL ptr_first got=%b src=%0d want=1000 src=3", g4, if4.out_src);
        end
        tick();
        if4.req[3] = 1'b0;
        tick();
        total++; if (g4 !== 4'b0010 || if4.out_src !== 2'd1 || if4.out_data !== 8'h31) begin
            bad++; $display("FAIL ptr_wrap got=%b src=%0d d=%h want=0010 src=1 d=31",
                            g4, if4.out_src, if4.out_data);
        end
        tick();
        clear4();
    endtask

    // Three-beat burst from 0 under toggling ready; requester 1 waits throughout.
    task automatic test_burst_ready();
        logic rp [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int   beats = 0;
        int   seen  = 0;
        do_reset2();
        if2.req[0] = 1'b1; if2.req_last[0] = 1'b0; if2.req_data[0] = 8'h10;
        if2.req[1] = 1'b1; if2.req_last[1] = 1'b1; if2.req_data[1] = 8'hEE;
        if2.out_ready = 1'b1;
        tick();
        for (int b = 0; b < 5; b++) begin
            if2.req_data[0] = 8'h10 + 8'(beats);
            if2.req_last[0] = (beats == 2);
            if2.out_ready   = rp[b];
            #1;
            total++; if (g2 !== 2'b01 || if2.out_valid !== 1'b1 || if2.out_src !== 1'b0) begin
                bad++; $display("FAIL burst_hold%0d got gnt=%b v=%b s=%0d want 01 1 0",
                                b, g2, if2.out_valid, if2.out_src);
            end
            total++; if (if2.out_data !== 8'h10 + 8'(beats) || if2.out_last !== (beats == 2)) begin
                bad++; $display("FAIL burst_beat%0d got d=%h l=%b want d=%h l=%b", b,
                                if2.out_data, if2.out_last, 8'h10 + 8'(beats), (beats == 2));
            end
            if (if2.out_valid && if2.out_ready) seen++;
            if (rp[b]) beats++;
            tick();
        end
        total++; if (g2 !== 2'b00 || if2.out_valid !== 1'b0) begin
            bad++; $display("FAIL burst_end got gnt=%b v=%b want 00 0", g2, if2.out_valid);
        end
        total++; if (seen !== 3) begin bad++; $display("FAIL burst_xfers got=%0d want=3", seen); end
        tick();
        total++; if (g2 !== 2'b10 || if2.out_src !== 1'b1 || if2.out_data !== 8'hEE) begin
            bad++; $display("FAIL burst_next got=%b s=%0d d=%h want 10 1 ee",
                            g2, if2.out_src, if2.out_data);
        end
        if2.out_ready = 1'b1;
        tick();
        clear2();
    endtask

    // Owner 0 drops its request mid-burst: released without transfer, 1 goes next.
    task automatic test_abort();
        do_reset2();
        if2.req[0] = 1'b1; if2.req_last[0] = 1'b0;
        if2.req[1] = 1'b1; if2.req_last[1] = 1'b1;
        if2.out_ready = 1'b0;
        tick();
        total++; if (g2 !== 2'b01 || if2.out_valid !== 1'b1) begin
            bad++; $display("FAIL abort_pre got gnt=%b v=%b want 01 1", g2, if2.out_valid);
        end
        if2.req[0] = 1'b0;
        #1;
        total++; if (if2.out_valid !== 1'b0 || g2 !== 2'b01) begin
            bad++; $display("FAIL abort_drop got gnt=%b v=%b want 01 0", g2, if2.out_valid);
        end
        tick();
        total++; if (g2 !== 2'b00) begin bad++; $display("FAIL abort_clear got=%b want=00", g2); end
        if2.req[0] = 1'b1;
        tick();
        total++; if (g2 !== 2'b10 || if2.out_src !== 1'b1) begin
            bad++; $display("FAIL abort_next got=%b s=%0d want 10 1", g2, if2.out_src);
        end
        if2.out_ready = 1'b1;
        tick();
        clear2();
    endtask

    // Reset during owner 2's last-beat transfer: pointer returns to 0, so 2 beats 3.
    task automatic test_reset_mid();
        do_reset4();
        if4.req[2] = 1'b1; if4.req_last[2] = 1'b0; if4.req_data[2] = 8'h5A;
        if4.out_ready = 1'b1;
        tick();
        total++; if (g4 !== 4'b0100 || if4.out_src !== 2'd2 || if4.out_data !== 8'h5A) begin
            bad++; $display("FAIL rmid_pre got=%b s=%0d d=%h want 0100 2 5a",
                            g4, if4.out_src, if4.out_data);
        end
        rst4 = 1'b1;
        if4.req_last[2] = 1'b1;
        if4.req[3] = 1'b1; if4.req_last[3] = 1'b1;
        tick();
        total++; if (g4 !== 4'b0000 || if4.out_valid !== 1'b0) begin
            bad++; $display("FAIL rmid_clear got gnt=%b v=%b want 0000 0", g4, if4.out_valid);
        end
        rst4 = 1'b0;
        tick();
        total++; if (g4 !== 4'b0100) begin bad++; $display("FAIL rmid_regrant got=%b want=0100", g4); end
        tick();
        clear4();
    endtask

    // Single requester held high: grant alternates, source index stays 0.
    task automatic test_single();
        logic e;
        do_reset1();
        if1.req[0] = 1'b1; if1.req_last[0] = 1'b1; if1.req_data[0] = 8'h77;
        if1.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            e = (k % 2 == 0);
            total++; if (g1 !== e || if1.out_src !== 1'b0) begin
                bad++; $display("FAIL single%0d got gnt=%b s=%0d want gnt=%b s=0", k, g1, if1.out_src, e);
            end
            total++; if (if1.out_data !== (e ? 8'h77 : 8'h00)) begin
                bad++; $display("FAIL single_data%0d got=%h want=%h", k, if1.out_data, e ? 8'h77 : 8'h00);
            end
        end
        clear1();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst4 = 1'b1; rst2 = 1'b1; rst1 = 1'b1;
        clear4(); clear2(); clear1();
        test_reset();
        test_rr_order();
        test_ptr_skip();
        test_burst_ready();
        test_abort();
        test_reset_mid();
        test_single();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
